// File: rtl/adder_bist_pkg.sv
// Shared types, sizes and golden full-adder functions for the adder BIST engine.
package adder_bist_pkg;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned SETTLE_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic full_add_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    function automatic logic full_add_carry(input logic a, input logic b, input logic cin);
        return (a & b) | (cin & (a ^ b));
    endfunction

endpackage

// File: rtl/adder_bist_golden.sv
// Combinational reference full adder used as the BIST golden model.
module adder_bist_golden
    import adder_bist_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic z_exp_o,
    output logic cout_exp_o
);

    assign z_exp_o    = full_add_sum(a_i, b_i, cin_i);
    assign cout_exp_o = full_add_carry(a_i, b_i, cin_i);

endmodule

// File: rtl/adder_bist.sv
// Clocked exhaustive self-test of a 1-bit full adder sitting beside this block.
// Define ADDER_BIST_COUT_CHECK_EN to also compare the carry output.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  z_i,
    input  logic                  cout_i,
    output logic                  a_o,
    output logic                  b_o,
    output logic                  cin_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [CNT_W-1:0]      fail_count_o,
    output logic [VEC_W-1:0]      first_fail_o
);

    state_e                state_q, state_d;
    logic [VEC_W-1:0]      vec_q, vec_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [CNT_W-1:0]      fail_q, fail_d;
    logic [VEC_W-1:0]      first_q, first_d;
    logic [VEC_W-1:0]      stim_q, stim_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;

    logic                  z_exp;
    logic                  cout_exp;
    logic                  mismatch;
    logic                  last_settle;
    logic                  last_vec;

    adder_bist_golden u_golden (
        .a_i        (stim_q[2]),
        .b_i        (stim_q[1]),
        .cin_i      (stim_q[0]),
        .z_exp_o    (z_exp),
        .cout_exp_o (cout_exp)
    );

`ifdef ADDER_BIST_COUT_CHECK_EN
    assign mismatch = (z_i != z_exp) || (cout_i != cout_exp);
`else
    logic unused_cout;
    assign unused_cout = cout_i ^ cout_exp;
    assign mismatch    = (z_i != z_exp);
`endif

    assign last_settle = (settle_q == SETTLE_W'(SETTLE - 1));
    assign last_vec    = (vec_q == VEC_W'(NUM_VECTORS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured while not running
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i)     state_d = ST_WAIT;
            ST_WAIT:  if (last_settle) state_d = ST_CHECK;
            ST_CHECK: state_d = last_vec ? ST_DONE : ST_WAIT;
            ST_DONE:  if (start_i)     state_d = ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        vec_d    = vec_q;
        settle_d = settle_q;
        fail_d   = fail_q;
        first_d  = first_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    vec_d    = '0;
                    settle_d = '0;
                    fail_d   = '0;
                    first_d  = '0;
                end
            end
            ST_WAIT: begin
                settle_d = settle_q + SETTLE_W'(1);
            end
            ST_CHECK: begin
                if (mismatch && (fail_q != CNT_W'(NUM_VECTORS))) begin
                    fail_d = fail_q + CNT_W'(1);
                    if (fail_q == '0) begin
                        first_d = vec_q;
                    end
                end
                if (!last_vec) begin
                    vec_d    = vec_q + VEC_W'(1);
                    settle_d = '0;
                end
            end
            default: ;
        endcase

        busy_d = (state_d == ST_WAIT) || (state_d == ST_CHECK);
        stim_d = busy_d ? vec_d : '0;
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (fail_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q    <= '0;
            settle_q <= '0;
            fail_q   <= '0;
            first_q  <= '0;
            stim_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            vec_q    <= vec_d;
            settle_q <= settle_d;
            fail_q   <= fail_d;
            first_q  <= first_d;
            stim_q   <= stim_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign a_o          = stim_q[2];
    assign b_o          = stim_q[1];
    assign cin_o        = stim_q[0];
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign fail_count_o = fail_q;
    assign first_fail_o = first_q;

endmodule
